// File: rtl/ysyx_22040386_id_ex_stage_pkg.sv
// Shared widths and operand-select encodings for the ID->EX stage.
package ysyx_22040386_id_ex_stage_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    SRC1_RS1  = 2'd0,
    SRC1_PC   = 2'd1,
    SRC1_ZERO = 2'd2
  } src1_sel_e;

  typedef enum logic [1:0] {
    SRC2_RS2    = 2'd0,
    SRC2_IMM    = 2'd1,
    SRC2_CONST4 = 2'd2
  } src2_sel_e;

  // No explicit store flag reaches this stage: a store is an imm-operand op
  // that neither writes rd nor loads, yet still consumes rs2 as store data.
  function automatic logic is_store(input logic [1:0] src2_sel, input logic rd_wen,
                                    input logic is_load);
    return (src2_sel == SRC2_IMM) && !rd_wen && !is_load;
  endfunction

endpackage

// File: rtl/ysyx_22040386_fwd_mux.sv
// Per-operand forwarding: picks EX/MEM/WB/regfile data and flags a load-use stall.
module ysyx_22040386_fwd_mux
  import ysyx_22040386_id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              used,
  input  logic              ex_valid,
  input  logic              ex_rd_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_result,
  input  logic              mem_wen,
  input  logic              mem_data_ok,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   data,
  output logic              stall
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic rs_nz;

  always_comb begin
    rs_nz   = (rs != '0);
    ex_hit  = ex_valid && ex_rd_wen && (ex_rd == rs);
    mem_hit = mem_wen && (mem_rd == rs);
    wb_hit  = wb_wen && (wb_rd == rs);

    data = rs_data;
    if (!rs_nz)                       data = '0;
    else if (ex_hit && !ex_is_load)   data = ex_result;
    else if (mem_hit && mem_data_ok)  data = mem_data;
    else if (wb_hit)                  data = wb_data;

    stall = used && rs_nz && ((ex_hit && ex_is_load) || (mem_hit && !mem_data_ok));
  end

endmodule

// File: rtl/ysyx_22040386_id_ex_stage.sv
// ID->EX pipeline register: handshake, operand forwarding/select, load-use stall, flush.
module ysyx_22040386_id_ex_stage
  import ysyx_22040386_id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [1:0]        in_src1_sel,
  input  logic [1:0]        in_src2_sel,
  input  logic [5:0]        in_aluctr,
  input  logic              in_word_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_wen,
  input  logic              in_is_load,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic              mem_data_ok,
  input  logic [XLEN-1:0]   mem_data,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_wen,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_src1,
  output logic [XLEN-1:0]   out_src2,
  output logic [5:0]        out_aluctr,
  output logic              out_word_op,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_rd_wen,
  output logic              out_is_load
);

  logic            used1, used2;
  logic            stall1, stall2;
  logic            hazard, capture, out_fire;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] src1_d, src2_d;

  assign used1 = (in_src1_sel == SRC1_RS1);
  assign used2 = (in_src2_sel == SRC2_RS2) || is_store(in_src2_sel, in_rd_wen, in_is_load);

  ysyx_22040386_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs(in_rs1), .rs_data(in_rs1_data), .used(used1),
    .ex_valid(out_valid), .ex_rd_wen(out_rd_wen), .ex_is_load(out_is_load),
    .ex_rd(out_rd), .ex_result(alu_result),
    .mem_wen(mem_wen), .mem_data_ok(mem_data_ok), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs1_val), .stall(stall1)
  );

  ysyx_22040386_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs(in_rs2), .rs_data(in_rs2_data), .used(used2),
    .ex_valid(out_valid), .ex_rd_wen(out_rd_wen), .ex_is_load(out_is_load),
    .ex_rd(out_rd), .ex_result(alu_result),
    .mem_wen(mem_wen), .mem_data_ok(mem_data_ok), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .data(rs2_val), .stall(stall2)
  );

  assign hazard   = stall1 || stall2;
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign capture  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Select happens before the register so the ALU sees plain flopped operands.
  always_comb begin
    src1_d = '0;
    case (in_src1_sel)
      SRC1_RS1: src1_d = rs1_val;
      SRC1_PC:  src1_d = in_pc;
      default:  src1_d = '0;
    endcase
    src2_d = '0;
    case (in_src2_sel)
      SRC2_RS2:    src2_d = rs2_val;
      SRC2_IMM:    src2_d = in_imm;
      SRC2_CONST4: src2_d = XLEN'(4);
      default:     src2_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_src1    <= '0;
      out_src2    <= '0;
      out_aluctr  <= '0;
      out_word_op <= 1'b0;
      out_pc      <= '0;
      out_rs2_val <= '0;
      out_rd      <= '0;
      out_rd_wen  <= 1'b0;
      out_is_load <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid   <= 1'b1;
      out_src1    <= src1_d;
      out_src2    <= src2_d;
      out_aluctr  <= in_aluctr;
      out_word_op <= in_word_op;
      out_pc      <= in_pc;
      out_rs2_val <= rs2_val;
      out_rd      <= in_rd;
      out_rd_wen  <= in_rd_wen;
      out_is_load <= in_is_load;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule
